axis_rr_arbiter: RTL
====================

Name: axis_rr_arbiter

Overview:
- N-to-1 AXI-Stream packet arbiter that shares one downstream axis channel between NumIn requesters.
- Field widths come from axis_pkg (DataW=64, KeepW=8, IdW=8, DstW=8, UsrW=1).
- Round-robin at packet granularity: a grant holds from the first beat until the tlast beat is accepted.
- Output is fully registered (one pipeline stage) and sits in front of shared consumers such as DMA engines or egress MACs.

Parameters:
- NumIn, 4, number of slave inputs; legal range 2..16.
- GrantW, $clog2(NumIn), width of the grant index (derived, do not override).

Ports:
- aclk  in  1  clock; all logic is on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- s_tvalid  in  NumIn  per-input valid.
- s_tready  out  NumIn  per-input ready.
- s_tdata  in  NumIn*DataW  input i occupies bits [i*DataW +: DataW]; the other flattened buses use the same packing.
- s_tkeep  in  NumIn*KeepW  per-input keep.
- s_tlast  in  NumIn  per-input last.
- s_tid  in  NumIn*IdW  per-input id.
- s_tdest  in  NumIn*DstW  per-input dest.
- s_tuser  in  NumIn*UsrW  per-input user.
- m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser  out  1/DataW/KeepW/1/IdW/DstW/UsrW  master channel.
- m_tready  in  1  downstream ready.
- grant_idx  out  GrantW  input currently granted; valid while busy=1.
- busy  out  1  1 while a packet is locked.

Behaviour:
- Reset (aresetn=0, asynchronous): state=IDLE, rr_ptr=0, grant_idx=0, busy=0, s_tready=0, m_tvalid=0. All m_t* data fields reset to 0.
- States: IDLE and LOCKED.
- IDLE:
  - s_tready is all 0.
  - If any s_tvalid=1, the winner is the first asserted index scanning rr_ptr, rr_ptr+1, … modulo NumIn.
  - Next cycle: grant_idx=winner, busy=1, state=LOCKED.
  - If no s_tvalid is asserted, stay in IDLE.
  - Arbitration costs exactly one bubble cycle per packet.
- LOCKED:
  - out_ready = ~m_tvalid | m_tready.
  - s_tready[grant_idx] = out_ready; all other s_tready bits are 0.
  - A beat is accepted when s_tvalid[g] & s_tready[g].
  - On an accepted beat, all s_* fields of input g load into the m_* registers, and m_tvalid=1 next cycle.
  - On an accepted beat with s_tlast[g]=1: next cycle state=IDLE, busy=0, rr_ptr=(g+1) mod NumIn.
- Output register:
  - If load, m_tvalid<=1.
  - Else if m_tready, m_tvalid<=0.
  - Data fields change only on load.
  - Full throughput: one beat per cycle while LOCKED with m_tready=1.
  - Latency: accepted input beat appears on m_* the following cycle.
- AXIS rules:
  - m_* is held stable while m_tvalid & ~m_tready.
  - s_tready never depends combinationally on s_tvalid.
  - m_tvalid does not depend on m_tready within the same cycle.
- Boundaries:
  - The granted input dropping s_tvalid mid-packet keeps the lock; no timeout.
  - Other inputs raising s_tvalid mid-packet see s_tready=0 until they win arbitration.
  - The tlast beat being accepted while other requesters wait: arbitration happens in the following IDLE cycle, and the last m_* beat can still be draining.
  - A single-beat packet occupies 2 cycles (IDLE + LOCKED).
  - rr_ptr wraps from NumIn-1 to 0.
  - The pointer advances only on packet completion, never on IDLE cycles with no requests.
  - Reset mid-packet: the packet is truncated, m_tvalid drops immediately, and the upstream must resend.
- grant_idx holds its last value while IDLE.

Test Plan:
- Reset, then single requester: input 2 sends a 3-beat packet with tdata 0xA0,0xA1,0xA2, tlast on the 3rd, m_tready=1. Expect one bubble, then m_tdata 0xA0/0xA1/0xA2 on consecutive cycles with m_tlast on 0xA2. Then busy=0 and rr_ptr=3.
- Fairness: all 4 inputs hold continuous 1-beat packets. Expect grant order 0,1,2,3,0,1 and m_tid matching the per-input tids 0x10..0x13.
- Backpressure: m_tready toggles 1,0,0,1 during a 4-beat packet from input 1. Expect m_* stable while stalled, no beat lost or duplicated, and s_tready[1]=0 only when the register is full and m_tready=0.
- Lock hold: input 0 mid-packet deasserts s_tvalid for 5 cycles while input 3 requests. Expect s_tready[3]=0 throughout, busy=1, and input 0 resumes and completes before input 3 is granted.
- Wrap and skip: rr_ptr=3 with requests only on inputs 1 and 2. Expect input 1 granted (scan 3→0→1), then input 2.
- Async reset at beat 2 of a 4-beat packet: expect m_tvalid=0, s_tready=0, busy=0 during reset with no clock edge. After release, a fresh arbitration starts from input 0.

Source files
------------

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter: round-robin at packet granularity with a
// single registered output stage feeding one shared downstream channel.

package axis_pkg;
   localparam int unsigned DataW = 64;
   localparam int unsigned KeepW = 8;
   localparam int unsigned IdW   = 8;
   localparam int unsigned DstW  = 8;
   localparam int unsigned UsrW  = 1;
endpackage

module axis_rr_arbiter
   import axis_pkg::*;
#(
   parameter  int unsigned NumIn  = 4,
   localparam int unsigned GrantW = $clog2(NumIn)
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [NumIn-1:0]         s_tvalid,
   output logic [NumIn-1:0]         s_tready,
   input  logic [NumIn*DataW-1:0]   s_tdata,
   input  logic [NumIn*KeepW-1:0]   s_tkeep,
   input  logic [NumIn-1:0]         s_tlast,
   input  logic [NumIn*IdW-1:0]     s_tid,
   input  logic [NumIn*DstW-1:0]    s_tdest,
   input  logic [NumIn*UsrW-1:0]    s_tuser,
   output logic                     m_tvalid,
   output logic [DataW-1:0]         m_tdata,
   output logic [KeepW-1:0]         m_tkeep,
   output logic                     m_tlast,
   output logic [IdW-1:0]           m_tid,
   output logic [DstW-1:0]          m_tdest,
   output logic [UsrW-1:0]          m_tuser,
   input  logic                     m_tready,
   output logic [GrantW-1:0]        grant_idx,
   output logic                     busy
);

   typedef enum logic {
      IDLE,
      LOCKED
   } state_e;

   state_e            state_q, state_d;
   logic [GrantW-1:0] rr_ptr_q, rr_ptr_d;
   logic [GrantW-1:0] grant_q, grant_d;
   logic              m_tvalid_q, m_tvalid_d;
   logic [DataW-1:0]  m_tdata_q;
   logic [KeepW-1:0]  m_tkeep_q;
   logic              m_tlast_q;
   logic [IdW-1:0]    m_tid_q;
   logic [DstW-1:0]   m_tdest_q;
   logic [UsrW-1:0]   m_tuser_q;

   logic [GrantW-1:0] winner;
   logic              any_req;
   logic              out_ready;
   logic              load;

   logic [DataW-1:0]  in_data [NumIn];
   logic [KeepW-1:0]  in_keep [NumIn];
   logic [IdW-1:0]    in_id   [NumIn];
   logic [DstW-1:0]   in_dest [NumIn];
   logic [UsrW-1:0]   in_user [NumIn];

   for (genvar gi = 0; gi < NumIn; gi++) begin : g_unpack
      assign in_data[gi] = s_tdata[gi*DataW +: DataW];
      assign in_keep[gi] = s_tkeep[gi*KeepW +: KeepW];
      assign in_id[gi]   = s_tid[gi*IdW +: IdW];
      assign in_dest[gi] = s_tdest[gi*DstW +: DstW];
      assign in_user[gi] = s_tuser[gi*UsrW +: UsrW];
   end

   // Scan rr_ptr, rr_ptr+1, ... (mod NumIn); one extra bit keeps the sum exact
   // so the modulo is a single conditional subtract for any NumIn.
   always_comb begin
      logic [GrantW:0] sum;
      sum     = '0;
      winner  = '0;
      any_req = 1'b0;
      for (int unsigned k = 0; k < NumIn; k++) begin
         sum = {1'b0, rr_ptr_q} + (GrantW+1)'(k);
         if (sum >= (GrantW+1)'(NumIn)) begin
            sum = sum - (GrantW+1)'(NumIn);
         end
         if (!any_req && s_tvalid[sum[GrantW-1:0]]) begin
            winner  = sum[GrantW-1:0];
            any_req = 1'b1;
         end
      end
   end

   assign out_ready = ~m_tvalid_q | m_tready;
   assign load      = (state_q == LOCKED) & s_tvalid[grant_q] & out_ready;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      unique case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = LOCKED;
               grant_d = winner;
            end
         end
         LOCKED: begin
            if (load && s_tlast[grant_q]) begin
               state_d  = IDLE;
               rr_ptr_d = (grant_q == GrantW'(NumIn-1)) ? '0 : grant_q + GrantW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_tready = '0;
      busy     = 1'b0;
      if (state_q == LOCKED) begin
         s_tready[grant_q] = out_ready;
         busy              = 1'b1;
      end
   end

   always_comb begin
      m_tvalid_d = m_tvalid_q;
      if (load) begin
         m_tvalid_d = 1'b1;
      end else if (m_tready) begin
         m_tvalid_d = 1'b0;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tkeep_q  <= '0;
         m_tlast_q  <= 1'b0;
         m_tid_q    <= '0;
         m_tdest_q  <= '0;
         m_tuser_q  <= '0;
      end else begin
         m_tvalid_q <= m_tvalid_d;
         if (load) begin
            m_tdata_q <= in_data[grant_q];
            m_tkeep_q <= in_keep[grant_q];
            m_tlast_q <= s_tlast[grant_q];
            m_tid_q   <= in_id[grant_q];
            m_tdest_q <= in_dest[grant_q];
            m_tuser_q <= in_user[grant_q];
         end
      end
   end

   assign m_tvalid  = m_tvalid_q;
   assign m_tdata   = m_tdata_q;
   assign m_tkeep   = m_tkeep_q;
   assign m_tlast   = m_tlast_q;
   assign m_tid     = m_tid_q;
   assign m_tdest   = m_tdest_q;
   assign m_tuser   = m_tuser_q;
   assign grant_idx = grant_q;

endmodule
